// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment controller.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // States of the sequential binary-to-BCD converter.
    typedef enum logic [1:0] {
        CV_IDLE,
        CV_SHIFT,
        CV_CHECK
    } conv_state_t;

    // Standard hex glyphs 0-F, active-low.
    function automatic logic [6:0] hex2seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: W = 4*NUM_DIGITS shift cycles followed
// by one check cycle in which done pulses and bcd/ovf are valid.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   start      accepted only while idle; captures bin
//   bin        unsigned binary input
//   bcd        NUM_DIGITS packed BCD digits (valid while done=1)
//   ovf        input exceeded 10^NUM_DIGITS-1 (valid while done=1)
//   busy       conversion running (shift or check cycle)
//   done       single-cycle completion pulse
module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] bin,
    output logic [DIGIT_W*NUM_DIGITS-1:0] bcd,
    output logic                          ovf,
    output logic                          busy,
    output logic                          done
);

    localparam int W     = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W = $clog2(W);

    conv_state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W-1:0]     shift_reg, shift_next;
    logic [W-1:0]     bcd_reg, bcd_next;
    logic [W-1:0]     bcd_adj;
    logic             lost_reg, lost_next;

    // Add-3 correction on every BCD digit that is 5 or more before shifting.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*DIGIT_W +: DIGIT_W] =
                (bcd_reg[gi*DIGIT_W +: DIGIT_W] >= 4'd5) ?
                bcd_reg[gi*DIGIT_W +: DIGIT_W] + 4'd3 :
                bcd_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CV_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            bcd_reg   <= '0;
            lost_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            bcd_reg   <= bcd_next;
            lost_reg  <= lost_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        bcd_next   = bcd_reg;
        lost_next  = lost_reg;
        case (state_reg)
            CV_IDLE: begin
                if (start) begin
                    state_next = CV_SHIFT;
                    cnt_next   = '0;
                    shift_next = bin;
                    bcd_next   = '0;
                    lost_next  = 1'b0;
                end
            end
            CV_SHIFT: begin
                // A 1 pushed out of the top digit means the value needs
                // more digits than the display has; the flag is sticky.
                {bcd_next, shift_next} = {bcd_adj[W-2:0], shift_reg, 1'b0};
                lost_next = lost_reg | bcd_adj[W-1];
                cnt_next  = cnt_reg + 1'b1;
                if (cnt_reg == CNT_W'(W - 1)) begin
                    state_next = CV_CHECK;
                end
            end
            default: begin
                state_next = CV_IDLE;
            end
        endcase
    end

    assign bcd  = bcd_reg;
    assign ovf  = lost_reg;
    assign busy = (state_reg != CV_IDLE);
    assign done = (state_reg == CV_CHECK);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment display controller.
// Holds a display buffer plus blank/dp/blink masks, scans one digit per slot
// with a blank gap at the start of each slot, and supports hex or decimal
// (binary-to-BCD) loading with atomic buffer updates.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   load         capture request, ignored while busy
//   data_in      hex nibbles or unsigned binary value (mode_dec)
//   mode_dec     1 = decimal conversion, 0 = hex nibbles
//   lz_suppress  blank leading zeros
//   blank_mask   digits permanently off
//   dp_mask      digits with decimal point lit
//   blink_mask   digits that blink
//   busy         decimal conversion in progress
//   ovf          last decimal load did not fit
//   seg, an, dp  registered active-low display pins
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_CYCLES = 262144,
    parameter int BLANK_CYCLES = 1024,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] data_in,
    input  logic                          mode_dec,
    input  logic                          lz_suppress,
    input  logic [NUM_DIGITS-1:0]         blank_mask,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    output logic                          busy,
    output logic                          ovf,
    output logic [6:0]                    seg,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          dp
);

    localparam int W      = DIGIT_W * NUM_DIGITS;
    localparam int SLOT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1)   ? $clog2(NUM_DIGITS)   : 1;
    localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(DIGIT_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);

    // Displayed state
    logic [W-1:0]            buf_reg;
    logic [NUM_DIGITS-1:0]   blank_reg, dp_mask_reg, blink_reg;
    logic                    lz_reg, ovf_reg;
    // Masks captured with a decimal load, applied when conversion completes
    logic [NUM_DIGITS-1:0]   pend_blank_reg, pend_dp_reg, pend_blink_reg;
    logic                    pend_lz_reg;

    // Scan state
    logic [SLOT_W-1:0]       slot_reg, slot_next;
    logic [IDX_W-1:0]        idx_reg, idx_next;
    logic [FRM_W-1:0]        frame_reg, frame_next;
    logic                    phase_reg, phase_next;

    // Output registers
    logic [6:0]              seg_reg, seg_next;
    logic [NUM_DIGITS-1:0]   an_reg, an_next;
    logic                    dp_reg, dp_next;

    logic                    accept;
    logic                    conv_busy, conv_done, conv_ovf;
    logic [W-1:0]            conv_bcd;
    logic [3:0]              digit [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_off_vec;
    logic                    digit_off;
    logic                    above_zero;

    assign accept = load & ~conv_busy;

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (accept & mode_dec),
        .bin   (data_in),
        .bcd   (conv_bcd),
        .ovf   (conv_ovf),
        .busy  (conv_busy),
        .done  (conv_done)
    );

    // Buffer/mask update. A completing conversion and an accepted load can
    // never coincide because done only occurs while busy is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_reg        <= '0;
            blank_reg      <= '0;
            dp_mask_reg    <= '0;
            blink_reg      <= '0;
            lz_reg         <= 1'b0;
            ovf_reg        <= 1'b0;
            pend_blank_reg <= '0;
            pend_dp_reg    <= '0;
            pend_blink_reg <= '0;
            pend_lz_reg    <= 1'b0;
        end else begin
            if (accept && mode_dec) begin
                pend_blank_reg <= blank_mask;
                pend_dp_reg    <= dp_mask;
                pend_blink_reg <= blink_mask;
                pend_lz_reg    <= lz_suppress;
            end
            if (accept && !mode_dec) begin
                buf_reg     <= data_in;
                blank_reg   <= blank_mask;
                dp_mask_reg <= dp_mask;
                blink_reg   <= blink_mask;
                lz_reg      <= lz_suppress;
                ovf_reg     <= 1'b0;
            end else if (conv_done) begin
                buf_reg     <= conv_bcd;
                blank_reg   <= pend_blank_reg;
                dp_mask_reg <= pend_dp_reg;
                blink_reg   <= pend_blink_reg;
                lz_reg      <= pend_lz_reg;
                ovf_reg     <= conv_ovf;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = buf_reg[gi*DIGIT_W +: DIGIT_W];
        end
    endgenerate

    // lz_off_vec[i] is set when digit i and every digit above it are zero;
    // digit 0 is never suppressed.
    always_comb begin
        lz_off_vec = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            above_zero    = above_zero & (buf_reg[i*DIGIT_W +: DIGIT_W] == 4'd0);
            lz_off_vec[i] = above_zero;
        end
    end

    // Slot / digit / frame / blink-phase counters
    always_comb begin
        slot_next  = slot_reg + 1'b1;
        idx_next   = idx_reg;
        frame_next = frame_reg;
        phase_next = phase_reg;
        if (slot_reg == SLOT_LAST) begin
            slot_next = '0;
            if (idx_reg == IDX_LAST) begin
                idx_next = '0;
                if (frame_reg == FRM_LAST) begin
                    frame_next = '0;
                    phase_next = ~phase_reg;
                end else begin
                    frame_next = frame_reg + 1'b1;
                end
            end else begin
                idx_next = idx_reg + 1'b1;
            end
        end
    end

    // Blank gap dominates; then blank mask, blink, leading-zero suppression.
    assign digit_off = blank_reg[idx_reg]
                     | (phase_reg & blink_reg[idx_reg])
                     | (lz_reg & ~ovf_reg & lz_off_vec[idx_reg]);

    always_comb begin
        seg_next = SEG_BLANK;
        an_next  = '1;
        dp_next  = 1'b1;
        if ((slot_reg >= SLOT_BLANK) && !digit_off) begin
            seg_next         = ovf_reg ? SEG_DASH : hex2seg(digit[idx_reg]);
            an_next[idx_reg] = 1'b0;
            dp_next          = ~dp_mask_reg[idx_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_reg  <= '0;
            idx_reg   <= '0;
            frame_reg <= '0;
            phase_reg <= 1'b0;
            seg_reg   <= SEG_BLANK;
            an_reg    <= '1;
            dp_reg    <= 1'b1;
        end else begin
            slot_reg  <= slot_next;
            idx_reg   <= idx_next;
            frame_reg <= frame_next;
            phase_reg <= phase_next;
            seg_reg   <= seg_next;
            an_reg    <= an_next;
            dp_reg    <= dp_next;
        end
    end

    assign seg  = seg_reg;
    assign an   = an_reg;
    assign dp   = dp_reg;
    assign busy = conv_busy;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with short scan timing.
module tb_seg7_scan_ctrl;

    localparam logic [6:0] G0    = 7'h40;
    localparam logic [6:0] G1    = 7'h79;
    localparam logic [6:0] G2    = 7'h24;
    localparam logic [6:0] G3    = 7'h30;
    localparam logic [6:0] G4    = 7'h19;
    localparam logic [6:0] GA    = 7'h08;
    localparam logic [6:0] GF    = 7'h0E;
    localparam logic [6:0] GDASH = 7'h3F;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic        mode_dec = 1'b0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  dp_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        busy, ovf, dp;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int errors = 0;
    int cyc;
    int lit_cnt [4];
    int dp_low [4];
    logic [6:0] seg_seen [4];
    int gap_bad, multi_bad;
    int nbusy;
    int exp_blink [4] = '{0, 0, 6, 6};

    seg7_scan_ctrl #(
        .NUM_DIGITS   (4),
        .DIGIT_CYCLES (8),
        .BLANK_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .data_in     (data_in),
        .mode_dec    (mode_dec),
        .lz_suppress (lz_suppress),
        .blank_mask  (blank_mask),
        .dp_mask     (dp_mask),
        .blink_mask  (blink_mask),
        .busy        (busy),
        .ovf         (ovf),
        .seg         (seg),
        .an          (an),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    // cyc equals the scan-state cycle index since the last reset edge
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_load(input logic dec, input logic [15:0] d, input logic lz,
                           input logic [3:0] bm, input logic [3:0] dm, input logic [3:0] km);
        mode_dec    = dec;
        data_in     = d;
        lz_suppress = lz;
        blank_mask  = bm;
        dp_mask     = dm;
        blink_mask  = km;
        load        = 1'b1;
        @(negedge clk);
        load        = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic observe(input int n);
        logic [3:0] sel;
        for (int i = 0; i < 4; i++) begin
            lit_cnt[i]  = 0;
            dp_low[i]   = 0;
            seg_seen[i] = 7'h7F;
        end
        gap_bad   = 0;
        multi_bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (an === 4'hF) begin
                if (seg !== 7'h7F || dp !== 1'b1) gap_bad++;
            end else if ($countones(~an) != 1) begin
                multi_bad++;
            end
            for (int i = 0; i < 4; i++) begin
                sel = 4'b0001 << i;
                if (an === ~sel) begin
                    lit_cnt[i]++;
                    seg_seen[i] = seg;
                    if (dp === 1'b0) dp_low[i]++;
                end
            end
        end
    endtask

    // segs = {digit3, digit2, digit1, digit0}
    task automatic check_frame(input string tag, input logic [3:0] lit_exp,
                               input logic [27:0] segs, input logic [3:0] dp_exp);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_lit%0d", tag, i), lit_cnt[i], lit_exp[i] ? 32'd6 : 32'd0);
            if (lit_exp[i]) begin
                check($sformatf("%s_seg%0d", tag, i), {25'd0, seg_seen[i]}, {25'd0, segs[i*7 +: 7]});
                check($sformatf("%s_dp%0d", tag, i), dp_low[i], dp_exp[i] ? 32'd6 : 32'd0);
            end
        end
        check({tag, "_gap"}, gap_bad, 0);
        check({tag, "_onehot"}, multi_bad, 0);
    endtask

    initial begin
        // Reset values and first lit cycle
        do_reset();
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_dp", dp, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        check("c1_an", an, 4'hF);
        @(negedge clk);
        check("c2_an", an, 4'hF);
        @(negedge clk);
        check("c3_an", an, 4'b1110);
        check("c3_seg", seg, G0);
        $display("reset and first-lit checks done");

        // Hex load 12AF
        do_load(1'b0, 16'h12AF, 1'b0, 4'h0, 4'h0, 4'h0);
        check("hex_busy", busy, 1'b0);
        wait_cyc(32);
        @(negedge clk);
        check("hex_gap0_an", an, 4'hF);
        @(negedge clk);
        check("hex_gap1_an", an, 4'hF);
        @(negedge clk);
        check("hex_d0_an", an, 4'b1110);
        check("hex_d0_seg", seg, GF);
        wait_cyc(64);
        observe(32);
        check_frame("hex12AF", 4'hF, {G1, G2, GA, GF}, 4'h0);
        $display("hex load 12AF checked");

        // Decimal 1234
        do_load(1'b1, 16'd1234, 1'b0, 4'h0, 4'h0, 4'h0);
        count_busy(nbusy);
        check("dec1234_busy_len", nbusy, 17);
        check("dec1234_ovf", ovf, 1'b0);
        observe(32);
        check_frame("dec1234", 4'hF, {G1, G2, G3, G4}, 4'h0);
        $display("decimal load 1234 checked");

        // Decimal 12345 overflows
        do_load(1'b1, 16'd12345, 1'b0, 4'h0, 4'h0, 4'h0);
        count_busy(nbusy);
        check("dec12345_busy_len", nbusy, 17);
        check("dec12345_ovf", ovf, 1'b1);
        observe(32);
        check_frame("ovf", 4'hF, {GDASH, GDASH, GDASH, GDASH}, 4'h0);
        $display("decimal overflow checked");

        // Decimal 42 with a hex load two cycles later that must be dropped
        do_load(1'b1, 16'd42, 1'b0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        do_load(1'b0, 16'h9999, 1'b0, 4'h0, 4'hF, 4'h0);
        count_busy(nbusy);
        check("dec42_busy_rest", nbusy, 15);
        check("dec42_ovf", ovf, 1'b0);
        observe(32);
        check_frame("dec42", 4'hF, {G0, G0, G4, G2}, 4'h0);
        $display("decimal 42 with dropped load checked");

        // Same with leading-zero suppression; a load on the completion cycle is dropped
        do_load(1'b1, 16'd42, 1'b1, 4'h0, 4'h0, 4'h0);
        repeat (16) @(negedge clk);
        do_load(1'b0, 16'h5555, 1'b0, 4'h0, 4'hF, 4'h0);
        check("lz42_busy_done", busy, 1'b0);
        @(negedge clk);
        observe(32);
        check_frame("lz42", 4'b0011, {G0, G0, G4, G2}, 4'h0);
        $display("leading-zero suppression checked");

        // Blink on digit 0, blank on digit 1, decimal point on digit 2
        do_reset();
        do_load(1'b0, 16'h12AF, 1'b0, 4'b0010, 4'b0100, 4'b0001);
        wait_cyc(64);
        for (int k = 0; k < 4; k++) begin
            observe(32);
            check($sformatf("blink_f%0d_lit0", k + 2), lit_cnt[0], exp_blink[k]);
            check($sformatf("blink_f%0d_lit1", k + 2), lit_cnt[1], 0);
            check($sformatf("blink_f%0d_lit2", k + 2), lit_cnt[2], 6);
            check($sformatf("blink_f%0d_seg2", k + 2), {25'd0, seg_seen[2]}, {25'd0, G2});
            check($sformatf("blink_f%0d_dp2", k + 2), dp_low[2], 6);
            check($sformatf("blink_f%0d_dp3", k + 2), dp_low[3], 0);
            check($sformatf("blink_f%0d_gap", k + 2), gap_bad, 0);
            $display("blink frame %0d: digit0 lit cycles %0d", k + 2, lit_cnt[0]);
        end

        // Reset in the middle of a decimal conversion
        do_load(1'b1, 16'd1234, 1'b0, 4'h0, 4'h0, 4'h0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_an", an, 4'hF);
        check("midrst_seg", seg, 7'h7F);
        check("midrst_dp", dp, 1'b1);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ovf", ovf, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        observe(32);
        check_frame("midrst", 4'hF, {G0, G0, G0, G0}, 4'h0);
        $display("reset during conversion checked");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
